lfsr_stream_engine: RTL and testbench
=====================================

# lfsr_stream_engine

Parametrised multi-bit LFSR random stream generator, the next generation of the single-bit random engine. Supports configurable register width, several output bits per cycle, runtime Fibonacci/Galois selection, bounded or unbounded word counts, a valid/ready output handshake with backpressure, and all-zero lock-up recovery. It sits between the control software interface (start/stop/config) and any downstream consumer of random words.

## Interface
- WIDTH, 16, LFSR register width; legal range 4..64.
- OUT_BITS, 4, bits emitted per output word; legal range 1..WIDTH.
- COUNT_W, 16, width of the word-count input.

- clk  in  1  single clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- start  in  1  begin a run; sampled only in IDLE.
- stop  in  1  end the run after the pending word drains.
- galois  in  1  mode, latched at start: 0 = Fibonacci, 1 = Galois.
- tap  in  WIDTH  tap mask, latched at start.
- seed  in  WIDTH  initial state, latched at start.
- count  in  COUNT_W  number of words to produce; 0 = unbounded.
- out_rdy  in  1  consumer ready.
- out_val  out  1  out_data holds a valid word.
- out_data  out  OUT_BITS  random word; bit 0 is the earliest emitted bit.
- active  out  1  high in RUN and DRAIN.
- lockup  out  1  sticky; all-zero state was substituted during this run.

## Operation
- FSM states: IDLE, RUN, DRAIN.
- Step definition, state s, emitted bit b = s[0]:
  - Fibonacci: fb = XOR-reduce(s & tap); next = {fb, s[WIDTH-1:1]}.
  - Galois: next = (s >> 1) ^ (b ? tap : 0).
  - If next == 0, substitute next = 1 and set lockup. The check is per step, inside the unrolled word.
- Word generation: OUT_BITS steps run combinationally from the current state. The word is captured into out_data, and the state advances by OUT_BITS steps.
- IDLE, start=1, stop=0:
  - Latch tap, galois, and words_left = count.
  - state = seed, or 1 if seed == 0; seed == 0 also sets lockup.
  - Clear lockup otherwise.
  - Go to RUN.
- Capture condition in RUN: (!out_val || out_rdy) && !stop && (count_latched == 0 || words_left != 0).
  - On capture: out_val = 1, and words_left decrements when bounded.
- Handshake: a transfer occurs when out_val && out_rdy.
  - A transfer without a capture clears out_val.
  - While out_val && !out_rdy, out_data, out_val and the LFSR state hold.
- RUN exits:
  - stop=1 with out_val=1 and no transfer: go to DRAIN.
  - stop=1 with no word pending after this edge: go to IDLE.
  - Bounded run, words_left == 0 and last word transferred: go to IDLE.
- DRAIN: no captures; on transfer, clear out_val and go to IDLE.
- start in RUN/DRAIN is ignored. start and stop together in IDLE: stop wins, stay IDLE.
- lockup is held through IDLE until the next accepted start.

## Timing
- Reset (rst=0): asynchronously force IDLE and clear out_val, out_data, active, lockup and the LFSR state to 0. Any run in progress is discarded.
- Start accepted at edge t: active=1 after t, out_val=0.
- First capture at edge t+1: out_val=1 after t+1.
- Steady state with out_rdy=1: one word per cycle, no bubbles.
- active falls on the edge that performs the final transfer (bounded) or the DRAIN transfer.
- out_val never rises in the same cycle that active falls.
- Stop asserted with no pending word: active=0 one edge later.

## Test plan
- Fibonacci, WIDTH=8, OUT_BITS=4, tap=8'h01, seed=8'h01, count=3, out_rdy=1 -> out_data 4'h1, 4'h0, 4'h1 on consecutive cycles starting 2 cycles after start; active drops with the third transfer; lockup=0.
- Galois, same widths, tap=8'hB8, seed=8'h01, count=0 -> first words 4'h1, then 4'h7; state after word 2 = 8'h64.
- Backpressure: run 1 with out_rdy=0 for 5 cycles after the first out_val -> out_data=4'h1 stable and out_val=1 throughout; after out_rdy=1, the next word is 4'h0, with no word skipped.
- Lock-up: Galois, tap=8'h00, seed=8'h01 -> every word 4'hF, lockup=1 from the first capture. Separately, seed=8'h00 -> lockup=1 one edge after start.
- Stop drain: stop pulsed while out_val=1 and out_rdy=0 -> state DRAIN, active=1 until out_rdy=1; the word transfers and active=0 after that edge. start+stop together in IDLE -> stays idle.
- Reset mid-run: drive rst=0 between edges while out_val=1 -> out_val, active, lockup and out_data all 0 immediately. After release, a new start reproduces the scenario 1 sequence.

Source files
------------

// File: rtl/lfsr_stream_engine_if.sv
// Output stream bus of the LFSR stream engine: one word per valid/ready transfer.
interface lfsr_stream_engine_if #(
    parameter int OUT_BITS = 4
);
    logic                out_val;
    logic                out_rdy;
    logic [OUT_BITS-1:0] out_data;

    modport master (output out_val, output out_data, input out_rdy);
    modport slave  (input out_val, input out_data, output out_rdy);
endinterface

// File: rtl/lfsr_stream_engine.sv
// Multi-bit LFSR random word generator with Fibonacci/Galois selection,
// bounded/unbounded runs, valid/ready backpressure and all-zero recovery.
module lfsr_stream_engine #(
    parameter int WIDTH    = 16,
    parameter int OUT_BITS = 4,
    parameter int COUNT_W  = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic               galois,
    input  logic [WIDTH-1:0]   tap,
    input  logic [WIDTH-1:0]   seed,
    input  logic [COUNT_W-1:0] count,
    output logic               active,
    output logic               lockup,
    lfsr_stream_engine_if.master bus
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    state_t              r_state;
    logic [WIDTH-1:0]    r_lfsr;
    logic [WIDTH-1:0]    r_tap;
    logic                r_galois;
    logic                r_bounded;
    logic [COUNT_W-1:0]  r_words_left;
    logic                r_out_val;
    logic [OUT_BITS-1:0] r_out_data;
    logic                r_active;
    logic                r_lockup;

    logic [WIDTH-1:0]    w_s;
    logic [WIDTH-1:0]    w_raw;
    logic [WIDTH-1:0]    w_next;
    logic [OUT_BITS-1:0] w_word;
    logic                w_lock;
    logic                w_xfer;
    logic                w_cap;

    // Unroll OUT_BITS steps from the current state; the zero check is per step
    // so a collapse in the middle of a word is recovered before the next bit.
    always_comb begin
        w_s    = r_lfsr;
        w_raw  = '0;
        w_word = '0;
        w_lock = 1'b0;
        for (int i = 0; i < OUT_BITS; i++) begin
            w_word[i] = w_s[0];
            if (r_galois)
                w_raw = (w_s >> 1) ^ (w_s[0] ? r_tap : '0);
            else
                w_raw = {^(w_s & r_tap), w_s[WIDTH-1:1]};
            if (w_raw == '0) begin
                w_raw  = ONE;
                w_lock = 1'b1;
            end
            w_s = w_raw;
        end
        w_next = w_s;
    end

    assign w_xfer = r_out_val && bus.out_rdy;
    assign w_cap  = (r_state == RUN) && (!r_out_val || bus.out_rdy) && !stop &&
                    (!r_bounded || r_words_left != '0);

    // Run control FSM; every output is a register updated here.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_lfsr       <= '0;
            r_tap        <= '0;
            r_galois     <= 1'b0;
            r_bounded    <= 1'b0;
            r_words_left <= '0;
            r_out_val    <= 1'b0;
            r_out_data   <= '0;
            r_active     <= 1'b0;
            r_lockup     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    // stop beats a simultaneous start
                    if (start && !stop) begin
                        r_tap        <= tap;
                        r_galois     <= galois;
                        r_words_left <= count;
                        r_bounded    <= (count != '0);
                        r_lfsr       <= (seed == '0) ? ONE : seed;
                        r_lockup     <= (seed == '0);
                        r_active     <= 1'b1;
                        r_state      <= RUN;
                    end
                end
                RUN: begin
                    if (w_cap) begin
                        r_out_val  <= 1'b1;
                        r_out_data <= w_word;
                        r_lfsr     <= w_next;
                        if (w_lock)
                            r_lockup <= 1'b1;
                        if (r_bounded)
                            r_words_left <= r_words_left - COUNT_W'(1);
                    end else if (w_xfer) begin
                        r_out_val <= 1'b0;
                    end
                    if (stop) begin
                        // a stalled word must still be delivered before going idle
                        if (r_out_val && !w_xfer) begin
                            r_state <= DRAIN;
                        end else begin
                            r_state  <= IDLE;
                            r_active <= 1'b0;
                        end
                    end else if (r_bounded && r_words_left == '0 && w_xfer) begin
                        r_state  <= IDLE;
                        r_active <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (w_xfer) begin
                        r_out_val <= 1'b0;
                        r_active  <= 1'b0;
                        r_state   <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.out_val  = r_out_val;
    assign bus.out_data = r_out_data;
    assign active       = r_active;
    assign lockup       = r_lockup;

endmodule

// File: tb/tb_lfsr_stream_engine.sv
// Directed bench for lfsr_stream_engine with WIDTH=8, OUT_BITS=4.
module tb_lfsr_stream_engine;

    localparam int WIDTH    = 8;
    localparam int OUT_BITS = 4;
    localparam int COUNT_W  = 16;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               start = 1'b0;
    logic               stop = 1'b0;
    logic               galois = 1'b0;
    logic [WIDTH-1:0]   tap = '0;
    logic [WIDTH-1:0]   seed = '0;
    logic [COUNT_W-1:0] count = '0;
    logic               active;
    logic               lockup;

    int errors = 0;
    int checks = 0;

    lfsr_stream_engine_if #(.OUT_BITS(OUT_BITS)) bus ();

    lfsr_stream_engine #(.WIDTH(WIDTH), .OUT_BITS(OUT_BITS), .COUNT_W(COUNT_W)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .galois(galois),
        .tap(tap), .seed(seed), .count(count), .active(active), .lockup(lockup),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // advance one rising edge; inputs are driven and outputs sampled 1ns after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // pulse start for one edge with the given configuration
    task automatic do_start(input logic g, input logic [WIDTH-1:0] t,
                            input logic [WIDTH-1:0] s, input logic [COUNT_W-1:0] c);
        galois = g; tap = t; seed = s; count = c; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        bus.out_rdy = 1'b1;
        #3;
        checks++; if (active !== 1'b0) begin errors++; $display("FAIL reset_active got %b want 0", active); end
        checks++; if (bus.out_val !== 1'b0) begin errors++; $display("FAIL reset_val got %b want 0", bus.out_val); end
        checks++; if (bus.out_data !== 4'h0) begin errors++; $display("FAIL reset_data got %h want 0", bus.out_data); end
        checks++; if (lockup !== 1'b0) begin errors++; $display("FAIL reset_lockup got %b want 0", lockup); end
        rst = 1'b1;
        tick();
    endtask

    // Fibonacci tap 01 is a rotate: words 1,0,1
    task automatic test_fibonacci();
        logic [3:0] exp_w [3];
        exp_w[0] = 4'h1; exp_w[1] = 4'h0; exp_w[2] = 4'h1;
        bus.out_rdy = 1'b1;
        do_start(1'b0, 8'h01, 8'h01, 16'd3);
        checks++; if (active !== 1'b1) begin errors++; $display("FAIL fib_active_start got %b want 1", active); end
        checks++; if (bus.out_val !== 1'b0) begin errors++; $display("FAIL fib_val_start got %b want 0", bus.out_val); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (bus.out_val !== 1'b1) begin errors++; $display("FAIL fib_val%0d got %b want 1", i, bus.out_val); end
            checks++; if (bus.out_data !== exp_w[i]) begin errors++; $display("FAIL fib_word%0d got %h want %h", i, bus.out_data, exp_w[i]); end
            checks++; if (active !== 1'b1) begin errors++; $display("FAIL fib_active%0d got %b want 1", i, active); end
        end
        tick();
        checks++; if (active !== 1'b0) begin errors++; $display("FAIL fib_active_end got %b want 0", active); end
        checks++; if (bus.out_val !== 1'b0) begin errors++; $display("FAIL fib_val_end got %b want 0", bus.out_val); end
        checks++; if (lockup !== 1'b0) begin errors++; $display("FAIL fib_lockup got %b want 0", lockup); end
    endtask

    // Galois tap B8: words 1, 7, then 4 (from state 64), then stop with transfer
    task automatic test_galois();
        logic [3:0] exp_w [3];
        exp_w[0] = 4'h1; exp_w[1] = 4'h7; exp_w[2] = 4'h4;
        bus.out_rdy = 1'b1;
        do_start(1'b1, 8'hB8, 8'h01, 16'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (bus.out_data !== exp_w[i]) begin errors++; $display("FAIL gal_word%0d got %h want %h", i, bus.out_data, exp_w[i]); end
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        checks++; if (active !== 1'b0) begin errors++; $display("FAIL gal_stop_active got %b want 0", active); end
        checks++; if (bus.out_val !== 1'b0) begin errors++; $display("FAIL gal_stop_val got %b want 0", bus.out_val); end
    endtask

    task automatic test_backpressure();
        bus.out_rdy = 1'b0;
        do_start(1'b0, 8'h01, 8'h01, 16'd3);
        tick();
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (bus.out_val !== 1'b1) begin errors++; $display("FAIL bp_hold_val%0d got %b want 1", i, bus.out_val); end
            checks++; if (bus.out_data !== 4'h1) begin errors++; $display("FAIL bp_hold_data%0d got %h want 1", i, bus.out_data); end
        end
        bus.out_rdy = 1'b1;
        tick();
        checks++; if (bus.out_data !== 4'h0) begin errors++; $display("FAIL bp_word1 got %h want 0", bus.out_data); end
        tick();
        checks++; if (bus.out_data !== 4'h1) begin errors++; $display("FAIL bp_word2 got %h want 1", bus.out_data); end
        tick();
        checks++; if (active !== 1'b0) begin errors++; $display("FAIL bp_active_end got %b want 0", active); end
    endtask

    task automatic test_lockup();
        bus.out_rdy = 1'b1;
        // zero seed is replaced by 1 and flagged immediately
        do_start(1'b1, 8'h00, 8'h00, 16'd1);
        checks++; if (lockup !== 1'b1) begin errors++; $display("FAIL lk_seed0 got %b want 1", lockup); end
        tick();
        checks++; if (bus.out_data !== 4'hF) begin errors++; $display("FAIL lk_seed0_word got %h want f", bus.out_data); end
        tick();
        checks++; if (lockup !== 1'b1) begin errors++; $display("FAIL lk_idle_hold got %b want 1", lockup); end
        // nonzero seed clears lockup at start; tap 0 collapses every step
        do_start(1'b1, 8'h00, 8'h01, 16'd2);
        checks++; if (lockup !== 1'b0) begin errors++; $display("FAIL lk_clear got %b want 0", lockup); end
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++; if (bus.out_data !== 4'hF) begin errors++; $display("FAIL lk_word%0d got %h want f", i, bus.out_data); end
            checks++; if (lockup !== 1'b1) begin errors++; $display("FAIL lk_flag%0d got %b want 1", i, lockup); end
        end
        tick();
        checks++; if (active !== 1'b0) begin errors++; $display("FAIL lk_active_end got %b want 0", active); end
    endtask

    task automatic test_drain();
        bus.out_rdy = 1'b0;
        do_start(1'b0, 8'h01, 8'h01, 16'd0);
        tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        for (int i = 0; i < 2; i++) begin
            checks++; if (active !== 1'b1) begin errors++; $display("FAIL dr_active%0d got %b want 1", i, active); end
            checks++; if (bus.out_val !== 1'b1) begin errors++; $display("FAIL dr_val%0d got %b want 1", i, bus.out_val); end
            checks++; if (bus.out_data !== 4'h1) begin errors++; $display("FAIL dr_data%0d got %h want 1", i, bus.out_data); end
            tick();
        end
        bus.out_rdy = 1'b1;
        tick();
        checks++; if (active !== 1'b0) begin errors++; $display("FAIL dr_active_end got %b want 0", active); end
        checks++; if (bus.out_val !== 1'b0) begin errors++; $display("FAIL dr_val_end got %b want 0", bus.out_val); end
        // start with stop in IDLE is refused
        stop = 1'b1;
        do_start(1'b0, 8'h01, 8'h01, 16'd0);
        stop = 1'b0;
        tick();
        checks++; if (active !== 1'b0) begin errors++; $display("FAIL startstop_active got %b want 0", active); end
        checks++; if (bus.out_val !== 1'b0) begin errors++; $display("FAIL startstop_val got %b want 0", bus.out_val); end
    endtask

    task automatic test_reset_mid_run();
        bus.out_rdy = 1'b0;
        do_start(1'b1, 8'h00, 8'h00, 16'd0);
        tick();
        checks++; if (bus.out_data !== 4'hF) begin errors++; $display("FAIL rm_pre_data got %h want f", bus.out_data); end
        #2;
        rst = 1'b0;
        #1;
        checks++; if (bus.out_val !== 1'b0) begin errors++; $display("FAIL rm_val got %b want 0", bus.out_val); end
        checks++; if (active !== 1'b0) begin errors++; $display("FAIL rm_active got %b want 0", active); end
        checks++; if (lockup !== 1'b0) begin errors++; $display("FAIL rm_lockup got %b want 0", lockup); end
        checks++; if (bus.out_data !== 4'h0) begin errors++; $display("FAIL rm_data got %h want 0", bus.out_data); end
        #1;
        rst = 1'b1;
        tick();
        test_fibonacci();
    endtask

    initial begin
        bus.out_rdy = 1'b0;
        test_reset();
        test_fibonacci();
        test_galois();
        test_backpressure();
        test_lockup();
        test_drain();
        test_reset_mid_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
